manchester_serial_tx: RTL and testbench

Parametrised serial Manchester transmitter. It is the next generation of the team's parallel 8-bit Manchester encoder. It accepts a DATA_W-bit word over a valid/ready handshake, latches a per-word convention select, and shifts the word out MSB-first as a single-wire Manchester line. Each half-bit is held for a programmable number of clocks. It sits between the tile's user inputs (ui_in / uio_in) and an output pin, and reports frame status to the host.

---
 rtl/manchester_serial_tx.sv | 158 +++++++++++++++
 tb/tb_manchester_serial_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/manchester_serial_tx.sv
// Serial Manchester transmitter: valid/ready word in, MSB-first line out.
// Define MANCH_TX_PARITY_EN to append an even-parity bit after bit 0.
module manchester_serial_tx #(
    parameter int DATA_W   = 8,
    parameter int HALF_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx_out,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic [$clog2(DATA_W+1)-1:0]   bit_idx
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);
`ifdef MANCH_TX_PARITY_EN
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W);
`else
    localparam logic [IDX_W-1:0] IDX_LAST = '0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                mode_q, mode_d;
    logic                half_q, half_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   shifted;
    logic                next_bit;
    logic [IDX_W-1:0]    next_idx;
`ifdef MANCH_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    always_comb begin
        shifted = shift_q << 1;
`ifdef MANCH_TX_PARITY_EN
        // After bit 0 the stored parity bit takes the line, reported as index DATA_W.
        next_bit = (idx_q == '0) ? par_q : shifted[DATA_W-1];
        next_idx = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
`else
        next_bit = shifted[DATA_W-1];
        next_idx = idx_q - 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        mode_d  = mode_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        ready_d = ready_q;
`ifdef MANCH_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && ready_q) begin
                        shift_d = in_data;
                        mode_d  = in_mode;
                        half_d  = 1'b0;
                        cnt_d   = '0;
                        idx_d   = IDX_TOP;
                        // First half equals the bit in mode 0, its inverse in mode 1.
                        tx_d    = in_data[DATA_W-1] ^ in_mode;
                        state_d = SEND;
`ifdef MANCH_TX_PARITY_EN
                        par_d   = ^in_data;
`endif
                    end
                end
                SEND: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        if (!half_q) begin
                            half_d = 1'b1;
                            tx_d   = ~tx_q;
                        end else if (idx_q == IDX_LAST) begin
                            half_d  = 1'b0;
                            tx_d    = 1'b0;
                            state_d = DONE;
                        end else begin
                            half_d  = 1'b0;
                            shift_d = shifted;
                            idx_d   = next_idx;
                            tx_d    = next_bit ^ mode_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
            ready_d = (state_d == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            mode_q  <= 1'b0;
            half_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            mode_q  <= mode_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

`ifdef MANCH_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign in_ready  = ready_q;
    assign tx_out    = tx_q;
    assign bit_idx   = idx_q;
    assign tx_active = (state_q == SEND);
    // A DONE reached while frozen is only reported once ena returns.
    assign tx_done   = (state_q == DONE) && ena;

endmodule

// File: tb/tb_manchester_serial_tx.sv
// Directed bench for manchester_serial_tx: table of single frames plus
// back-to-back, freeze and mid-frame reset sequences.
module tb_manchester_serial_tx;

`ifdef MANCH_TX_PARITY_EN
    localparam int NH = 18;
`else
    localparam int NH = 16;
`endif
    localparam int HC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] in_data;
    logic       in_mode;
    logic       in_valid;
    logic       in_ready, tx_out, tx_active, tx_done;
    logic [3:0] bit_idx;

    logic       ena1;
    logic [7:0] in_data1;
    logic       in_mode1;
    logic       in_valid1;
    logic       in_ready1, tx_out1, tx_active1, tx_done1;
    logic [3:0] bit_idx1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    manchester_serial_tx #(.DATA_W(8), .HALF_CYC(HC), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid),
        .in_ready(in_ready), .tx_out(tx_out), .tx_active(tx_active),
        .tx_done(tx_done), .bit_idx(bit_idx)
    );

    manchester_serial_tx #(.DATA_W(8), .HALF_CYC(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena1),
        .in_data(in_data1), .in_mode(in_mode1), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx_out(tx_out1), .tx_active(tx_active1),
        .tx_done(tx_done1), .bit_idx(bit_idx1)
    );

    typedef struct {
        logic [7:0]  d;
        logic        m;
        logic [15:0] ex;
        logic [1:0]  ep;
        int          frz;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic hbit(input logic [15:0] ex, input logic [1:0] ep,
                                  input int h);
        return (h < 16) ? ex[15-h] : ep[17-h];
    endfunction

    function automatic logic [3:0] eidx(input int h);
        return (h < 16) ? 4'(7 - h / 2) : 4'd8;
    endfunction

    task automatic run_frame(input vec_t v);
        int   guard;
        logic hold_tx;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_frame", in_ready, 1);
        in_data  = v.d;
        in_mode  = v.m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~v.d;
        in_mode  = ~v.m;
        for (int k = 0; k < NH * HC; k++) begin
            chk("tx_out", tx_out, hbit(v.ex, v.ep, k / HC));
            chk("bit_idx", bit_idx, eidx(k / HC));
            chk("tx_active", tx_active, 1);
            chk("no_early_done", tx_done, 0);
            if (k == v.frz) begin
                hold_tx = tx_out;
                ena = 1'b0;
                for (int f = 0; f < 5; f++) begin
                    @(negedge clk);
                    chk("frozen_tx", tx_out, hold_tx);
                    chk("frozen_idx", bit_idx, eidx(k / HC));
                    chk("frozen_no_done", tx_done, 0);
                end
                ena = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_pulse", tx_done, 1);
        chk("done_inactive", tx_active, 0);
        chk("done_line_low", tx_out, 0);
        chk("done_not_ready", in_ready, 0);
        @(negedge clk);
        chk("done_once", tx_done, 0);
        chk("ready_after_done", in_ready, 1);
        chk("idle_line_low", tx_out, 0);
    endtask

    initial begin
        tbl[0] = '{8'hB2, 1'b0, 16'b1001101001011001, 2'b01, -1};
        tbl[1] = '{8'hB2, 1'b1, 16'b0110010110100110, 2'b10, -1};
        tbl[2] = '{8'hFF, 1'b0, 16'hAAAA, 2'b01, -1};
        tbl[3] = '{8'h00, 1'b1, 16'hAAAA, 2'b10, -1};
        tbl[4] = '{8'h01, 1'b0, 16'h5556, 2'b10, -1};
        tbl[5] = '{8'hB2, 1'b0, 16'b1001101001011001, 2'b01, 8};

        rst_n = 1'b0;
        ena = 1'b1;
        ena1 = 1'b1;
        in_data = '0;
        in_mode = 1'b0;
        in_valid = 1'b0;
        in_data1 = '0;
        in_mode1 = 1'b0;
        in_valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx_out", tx_out, 0);
        chk("rst_active", tx_active, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_idx", bit_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        // back-to-back on the HALF_CYC=1 instance, data changed mid-frame
        in_data1 = 8'hF0;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_data1 = 8'h0F;
        for (int t = 0; t < 2 * NH + 2; t++) begin
            if (t < NH) begin
                chk("b2b_f1", tx_out1, hbit(16'hAA55, 2'b01, t));
                chk("b2b_f1_act", tx_active1, 1);
            end else if (t == NH) begin
                chk("b2b_gap_done", tx_done1, 1);
                chk("b2b_gap0", tx_out1, 0);
            end else if (t == NH + 1) begin
                chk("b2b_gap_ready", in_ready1, 1);
                chk("b2b_gap1", tx_out1, 0);
            end else begin
                chk("b2b_f2", tx_out1, hbit(16'h55AA, 2'b01, t - NH - 2));
                chk("b2b_f2_act", tx_active1, 1);
            end
            if (t == 2 * NH + 1) in_valid1 = 1'b0;
            @(negedge clk);
        end
        chk("b2b_f2_done", tx_done1, 1);

        // reset in mid-frame aborts without a done pulse
        while (!in_ready) @(negedge clk);
        in_data = 8'h55;
        in_mode = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_active", tx_active, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx_out, 0);
        chk("mid_rst_active", tx_active, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_done", tx_done, 0);
        @(negedge clk);
        chk("mid_rst_done2", tx_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_back", in_ready, 1);
        chk("mid_rst_no_done", tx_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
